prog_mem_arbiter: RTL and testbench
===================================

Name: prog_mem_arbiter

Overview:
Shares the single main-memory request port between the MCU data bus and the serial programmer's write port.
- Programmer writes are single-cycle pulses with no backpressure, so they are queued in a small FIFO.
- The programmer's mcu_reset output, or any queued write, hands port ownership to the programmer.
- Each ownership change passes through a one-cycle turnaround with the memory port idle.
- Sits between programmer, MCU core and the memory wrapper.

Parameters:
FIFO_DEPTH, 4, programmer write queue depth; power of two, >=2
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
mcu_reset  in  1  programmer's MCU-reset request
prog_addr  in  ADDR_W  programmer write address
prog_data  in  DATA_W  programmer write data
prog_we  in  1  programmer write strobe, one-cycle pulse
prog_overflow  out  1  sticky: a programmer write was dropped
mcu_req  in  1  MCU memory request
mcu_we  in  1  MCU write enable (0 = read)
mcu_addr  in  ADDR_W  MCU address
mcu_wdata  in  DATA_W  MCU write data
mcu_gnt  out  1  MCU request accepted this cycle
mcu_hold  out  1  MCU must stall; port not owned by MCU
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ready  in  1  memory accepts request this cycle
busy  out  1  FIFO non-empty or state != ARB_MCU

Behaviour:
- Transfer occurs when mem_req && mem_ready. Once mem_req is asserted, address, data and we stay stable until accepted.
- Reset (async, any time, including mid-transfer):
  - state = ARB_MCU
  - FIFO emptied
  - prog_overflow = 0
  - Combinational outputs follow state: mem_req=0, mcu_gnt=0, mcu_hold=0, busy=0.
- FIFO:
  - Push on prog_we.
  - Write to a full FIFO with no pop that cycle: write dropped, prog_overflow set.
  - Push and pop in the same cycle while full: both succeed.
  - Head is registered show-ahead. Entry pushed in cycle N is visible at head in cycle N+1.
  - Occupancy counter width is $clog2(FIFO_DEPTH+1).
- prog_overflow clears only on rst or on a rising edge of mcu_reset.
- States:
  - ARB_MCU:
    - mem_* = mcu_* combinationally.
    - mcu_gnt = mcu_req && mem_ready.
    - mcu_hold = 0.
    - If (mcu_reset || FIFO non-empty) and !(mcu_req && !mem_ready): go to ARB_TO_PROG. An MCU request already stalled on the port completes first.
  - ARB_TO_PROG:
    - mem_req = 0, mcu_hold = 1.
    - Next cycle goes to ARB_PROG unconditionally.
  - ARB_PROG:
    - mem_req = FIFO non-empty, mem_we = 1, mem_addr/mem_wdata = FIFO head.
    - Pop on mem_ready.
    - mcu_hold = 1, mcu_gnt = 0.
    - If !mcu_reset and FIFO empty and no transfer this cycle: go to ARB_TO_MCU.
  - ARB_TO_MCU:
    - mem_req = 0, mcu_hold = 1.
    - Next cycle: go to ARB_TO_PROG if the FIFO became non-empty or mcu_reset rose; otherwise go to ARB_MCU.
- Minimum latency from prog_we (cycle N, FIFO previously empty, state ARB_MCU, MCU idle):
  - ARB_TO_PROG at N+1.
  - mem_req at N+2.
  - Pop at N+2 if mem_ready.
- While in ARB_PROG, prog_we in cycle N gives mem_req in cycle N+1.
- mcu_reset held high with empty FIFO: remains in ARB_PROG with mem_req=0.
- A write arriving in ARB_TO_MCU is queued, and the arbiter returns to the programmer after that cycle.

Decomposition:
- Package prog_arb_pkg:
  - typedef enum e_arb_state {ARB_MCU, ARB_TO_PROG, ARB_PROG, ARB_TO_MCU}
  - FIFO entry struct {addr, data}
- One sub-module: sync_fifo.
  - Parameters: DEPTH, WIDTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - Registered head, async reset.
- Arbiter top holds the FSM, output mux and overflow flag.

Test Plan:
- Idle MCU, mem_ready=1; pulse prog_we with addr 0x100, data 0xDEADBEEF at cycle 10 -> mem_req=1 at cycle 12 with we=1, 0x100/0xDEADBEEF; state back to ARB_MCU at cycle 14; busy low from cycle 14.
- mcu_reset=1, mem_ready=0; 5 back-to-back prog_we pulses (addr 0x0,0x4,...,0x10) -> first 4 queued, 5th dropped, prog_overflow=1. Release mem_ready -> exactly 4 writes, addresses 0x0..0xC in order.
- MCU read to 0x2000 stalled (mem_ready=0 for 3 cycles) when mcu_reset rises -> MCU transfer completes with mcu_gnt=1 first, then ARB_TO_PROG; mcu_hold=1 from the following cycle.
- FIFO full, mem_ready=1 and prog_we in the same cycle -> push accepted, no overflow, count stays 4.
- Assert rst mid-transfer with 3 entries queued -> same cycle: mem_req=0, busy=0, prog_overflow=0; after rst release, no stale writes issued.
- mcu_reset pulse 1->0 with overflow set, then 0->1 -> prog_overflow cleared on the rising edge; MCU regains the port only after the FIFO drains and mcu_reset=0.

Source files
------------

// File: rtl/prog_arb_pkg.sv
// rtl/prog_arb_pkg.sv - shared types for the programmer/MCU memory-port arbiter
package prog_arb_pkg;

  // Default bus widths of the memory port
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  // Port ownership: MCU, turnaround toward programmer, programmer, turnaround back
  typedef enum logic [1:0] {
    ARB_MCU,
    ARB_TO_PROG,
    ARB_PROG,
    ARB_TO_MCU
  } e_arb_state;

  // One queued programmer write at the default widths
  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] data;
  } prog_entry_t;

  // Packs an address/data pair into a queue entry at the default widths
  function automatic prog_entry_t make_entry(input logic [ARB_ADDR_W-1:0] addr,
                                             input logic [ARB_DATA_W-1:0] data);
    prog_entry_t e;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/prog_mem_arbiter_fifo.sv
// rtl/prog_mem_arbiter_fifo.sv - show-ahead synchronous FIFO for queued programmer writes
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot in the same cycle, so a full FIFO still takes a push alongside a pop
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

  // Head is read straight from the storage flops, so a push is visible the next cycle
  assign dout = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/prog_mem_arbiter.sv
// rtl/prog_mem_arbiter.sv - shares the memory port between the MCU bus and the programmer write queue
module prog_mem_arbiter
  import prog_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mcu_reset,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_we,
  output logic              prog_overflow,
  input  logic              mcu_req,
  input  logic              mcu_we,
  input  logic [ADDR_W-1:0] mcu_addr,
  input  logic [DATA_W-1:0] mcu_wdata,
  output logic              mcu_gnt,
  output logic              mcu_hold,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int ENT_W = ADDR_W + DATA_W;

  e_arb_state        state;
  logic              mcu_reset_q;
  logic              mcu_reset_rise;
  logic [ENT_W-1:0]  fifo_din;
  logic [ENT_W-1:0]  fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_pop;
  logic              prog_drained;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign fifo_din  = {prog_addr, prog_data};
  assign head_addr = fifo_dout[DATA_W +: ADDR_W];
  assign head_data = fifo_dout[DATA_W-1:0];

  // Queue entries are only consumed while the programmer owns the port
  assign fifo_pop = (state == ARB_PROG) && !fifo_empty && mem_ready;

  // True when the queue will be empty after this cycle and nothing new is arriving
  assign prog_drained = !prog_we &&
                        (fifo_empty || ((fifo_count == CNT_W'(1)) && fifo_pop));

  assign mcu_reset_rise = mcu_reset && !mcu_reset_q;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (prog_we),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Ownership FSM; an MCU request already stalled on the port finishes before handover
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_MCU;
    end else begin
      case (state)
        ARB_MCU: begin
          if ((mcu_reset || !fifo_empty || prog_we) && !(mcu_req && !mem_ready))
            state <= ARB_TO_PROG;
        end
        ARB_TO_PROG: state <= ARB_PROG;
        ARB_PROG: begin
          if (!mcu_reset && prog_drained)
            state <= ARB_TO_MCU;
        end
        ARB_TO_MCU: begin
          if (!fifo_empty || prog_we || mcu_reset_rise)
            state <= ARB_TO_PROG;
          else
            state <= ARB_MCU;
        end
        default: state <= ARB_MCU;
      endcase
    end
  end

  // Sticky drop flag; a fresh MCU-reset request from the programmer clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcu_reset_q   <= 1'b0;
      prog_overflow <= 1'b0;
    end else begin
      mcu_reset_q <= mcu_reset;
      if (prog_we && fifo_full && !fifo_pop)
        prog_overflow <= 1'b1;
      else if (mcu_reset_rise)
        prog_overflow <= 1'b0;
    end
  end

  // Memory port mux; the port is idle during both turnaround states and while in reset
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = mcu_addr;
    mem_wdata = mcu_wdata;
    mcu_gnt   = 1'b0;
    mcu_hold  = 1'b1;
    unique case (state)
      ARB_MCU: begin
        mem_req  = mcu_req;
        mem_we   = mcu_we;
        mcu_gnt  = mcu_req && mem_ready;
        mcu_hold = 1'b0;
      end
      ARB_PROG: begin
        mem_req   = !fifo_empty;
        mem_we    = 1'b1;
        mem_addr  = head_addr;
        mem_wdata = head_data;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
    if (rst) begin
      mem_req  = 1'b0;
      mcu_gnt  = 1'b0;
      mcu_hold = 1'b0;
    end
  end

  // Activity indicator for the programmer side
  assign busy = !rst && (!fifo_empty || (state != ARB_MCU));

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// tb/tb_prog_mem_arbiter.sv - directed self-checking bench for prog_mem_arbiter
module tb_prog_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          mcu_reset;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic          prog_we;
  logic          prog_overflow;
  logic          mcu_req;
  logic          mcu_we;
  logic [AW-1:0] mcu_addr;
  logic [DW-1:0] mcu_wdata;
  logic          mcu_gnt;
  logic          mcu_hold;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [AW-1:0] seen_addr[$];
  logic [DW-1:0] seen_data[$];

  always #5 clk = ~clk;

  prog_mem_arbiter #(
    .FIFO_DEPTH (4),
    .ADDR_W     (AW),
    .DATA_W     (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mcu_reset     (mcu_reset),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .prog_we       (prog_we),
    .prog_overflow (prog_overflow),
    .mcu_req       (mcu_req),
    .mcu_we        (mcu_we),
    .mcu_addr      (mcu_addr),
    .mcu_wdata     (mcu_wdata),
    .mcu_gnt       (mcu_gnt),
    .mcu_hold      (mcu_hold),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .busy          (busy)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to the drive point of the next cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Move to the sampling point of the current cycle
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic record();
    if (mem_req && mem_ready) begin
      seen_addr.push_back(mem_addr);
      seen_data.push_back(mem_wdata);
    end
  endtask

  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      settle();
      record();
      tick();
    end
  endtask

  task automatic push_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      settle();
      record();
      if (!mcu_hold && !busy) ok = 1'b1;
      tick();
      if (ok) break;
    end
    check_val(tag, ok, 1'b1);
  endtask

  initial begin
    rst = 1'b1; mcu_reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = 32'h55; mcu_wdata = '0; mem_ready = 1'b1;
    tick(); tick();
    settle();
    check_val("rst_mem_req", mem_req, 1'b0);
    check_val("rst_gnt", mcu_gnt, 1'b0);
    check_val("rst_hold", mcu_hold, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_ovf", prog_overflow, 1'b0);
    tick();
    mcu_req = 1'b0;
    rst = 1'b0;
    tick(); tick();

    // Single programmer write, minimum latency and return to MCU
    prog_we = 1'b1; prog_addr = 32'h100; prog_data = 32'hDEADBEEF;
    settle();
    check_val("t1_n0_hold", mcu_hold, 1'b0);
    check_val("t1_n0_req", mem_req, 1'b0);
    tick();
    prog_we = 1'b0;
    settle();
    check_val("t1_n1_req", mem_req, 1'b0);
    check_val("t1_n1_hold", mcu_hold, 1'b1);
    tick(); settle();
    check_val("t1_n2_req", mem_req, 1'b1);
    check_val("t1_n2_we", mem_we, 1'b1);
    check_val("t1_n2_addr", mem_addr, 32'h100);
    check_val("t1_n2_data", mem_wdata, 32'hDEADBEEF);
    tick(); settle();
    check_val("t1_n3_req", mem_req, 1'b0);
    check_val("t1_n3_busy", busy, 1'b1);
    tick(); settle();
    check_val("t1_n4_hold", mcu_hold, 1'b0);
    check_val("t1_n4_busy", busy, 1'b0);
    tick();

    // Stalled MCU read completes before the handover to the programmer
    mem_ready = 1'b0; mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = 32'h2000;
    settle();
    check_val("t3_req", mem_req, 1'b1);
    check_val("t3_addr", mem_addr, 32'h2000);
    check_val("t3_we", mem_we, 1'b0);
    check_val("t3_gnt0", mcu_gnt, 1'b0);
    tick();
    mcu_reset = 1'b1;
    settle();
    check_val("t3_stall1_hold", mcu_hold, 1'b0);
    check_val("t3_stall1_gnt", mcu_gnt, 1'b0);
    tick(); settle();
    check_val("t3_stall2_hold", mcu_hold, 1'b0);
    check_val("t3_stall2_req", mem_req, 1'b1);
    tick();
    mem_ready = 1'b1;
    settle();
    check_val("t3_gnt", mcu_gnt, 1'b1);
    check_val("t3_gnt_hold", mcu_hold, 1'b0);
    tick();
    mcu_req = 1'b0; mcu_reset = 1'b0;
    settle();
    check_val("t3_after_hold", mcu_hold, 1'b1);
    check_val("t3_after_req", mem_req, 1'b0);
    tick();
    wait_idle("t3_idle");

    // Overflow: four queued, fifth dropped, then drained in order
    mcu_reset = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      prog_we = 1'b1; prog_addr = 32'(i * 4); prog_data = 32'hA000 + 32'(i);
      if (i == 4) begin
        settle();
        check_val("t2_ovf_before", prog_overflow, 1'b0);
      end
      tick();
    end
    prog_we = 1'b0;
    settle();
    check_val("t2_ovf", prog_overflow, 1'b1);
    check_val("t2_stall_req", mem_req, 1'b1);
    check_val("t2_stall_addr", mem_addr, 32'h0);
    check_val("t2_stall_hold", mcu_hold, 1'b1);
    tick();
    mem_ready = 1'b1;
    seen_addr.delete(); seen_data.delete();
    collect(10);
    check_val("t2_count", seen_addr.size(), 4);
    for (int i = 0; i < 4 && i < seen_addr.size(); i++) begin
      check_val($sformatf("t2_addr%0d", i), seen_addr[i], 32'(i * 4));
      check_val($sformatf("t2_data%0d", i), seen_data[i], 32'hA000 + 32'(i));
    end
    settle();
    check_val("t2_held_req", mem_req, 1'b0);
    check_val("t2_held_hold", mcu_hold, 1'b1);
    tick();

    // Overflow survives mcu_reset falling, clears on its next rising edge
    mcu_reset = 1'b0;
    wait_idle("t6_idle1");
    settle();
    check_val("t6_ovf_kept", prog_overflow, 1'b1);
    tick();
    mem_ready = 1'b0;
    push_one(32'h200, 32'h1);
    push_one(32'h204, 32'h2);
    mcu_reset = 1'b1;
    tick(); settle();
    check_val("t6_ovf_clr", prog_overflow, 1'b0);
    tick();
    mcu_reset = 1'b0;
    settle();
    check_val("t6_hold_q1", mcu_hold, 1'b1);
    tick(); settle();
    check_val("t6_hold_q2", mcu_hold, 1'b1);
    tick();
    mem_ready = 1'b1;
    seen_addr.delete(); seen_data.delete();
    wait_idle("t6_idle2");
    check_val("t6_count", seen_addr.size(), 2);
    if (seen_addr.size() == 2) begin
      check_val("t6_addr0", seen_addr[0], 32'h200);
      check_val("t6_addr1", seen_addr[1], 32'h204);
    end

    // Push and pop together while full: both succeed
    mcu_reset = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(32'h300 + 32'(i * 4), 32'hB0 + 32'(i));
    tick(); tick();
    seen_addr.delete(); seen_data.delete();
    mem_ready = 1'b1; prog_we = 1'b1; prog_addr = 32'h310; prog_data = 32'hB4;
    settle();
    record();
    check_val("t4_pop_addr", mem_addr, 32'h300);
    tick();
    prog_we = 1'b0;
    settle();
    check_val("t4_ovf", prog_overflow, 1'b0);
    record();
    tick();
    collect(8);
    check_val("t4_count", seen_addr.size(), 5);
    for (int i = 0; i < 5 && i < seen_addr.size(); i++)
      check_val($sformatf("t4_addr%0d", i), seen_addr[i], 32'h300 + 32'(i * 4));
    mcu_reset = 1'b0;
    wait_idle("t4_idle");

    // Asynchronous reset mid-transfer with three entries queued
    mcu_reset = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_one(32'h400 + 32'(i * 4), 32'hC0 + 32'(i));
    tick();
    mem_ready = 1'b1;
    settle();
    check_val("t5_pre_req", mem_req, 1'b1);
    rst = 1'b1; mcu_reset = 1'b0;
    #1;
    check_val("t5_rst_req", mem_req, 1'b0);
    check_val("t5_rst_busy", busy, 1'b0);
    check_val("t5_rst_ovf", prog_overflow, 1'b0);
    check_val("t5_rst_hold", mcu_hold, 1'b0);
    tick();
    rst = 1'b0;
    seen_addr.delete(); seen_data.delete();
    collect(10);
    check_val("t5_stale", seen_addr.size(), 0);
    settle();
    check_val("t5_busy_after", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
